jtkunio_mcu_mbox: RTL and testbench
===================================

Name: jtkunio_mcu_mbox

Overview:
Mailbox between the Kunio main 6502 and the protection MCU (68705-style port interface). It is the MCU-facing end of the main CPU's MCU latch at I/O offset 4. The block holds one byte in each direction, with full flags. It drives the main CPU status bits mcu_st[1:0] and the MCU interrupt line. Both sides run on clk; each side accesses through its own strobes, and the block edge-detects them.

Parameters:
RSTVAL, 8'h00, reset value of both data latches

Ports:
clk  in  1  24 MHz system clock
rst  in  1  reset
main_cs  in  1  main CPU mailbox select, held for a whole CPU cycle
main_rnw  in  1  main CPU read(1)/write(0)
main_din  in  8  main CPU write data
main_dout  out  8  byte for main CPU reads
mcu_st  out  2  [0] m2s_full, [1] s2m_full
mcu_rd_n  in  1  MCU read strobe, active low
mcu_wr_n  in  1  MCU write strobe, active low
mcu_dout  in  8  MCU port A output data
mcu_din  out  8  byte presented to MCU port A
mcu_irqn  out  1  MCU interrupt, active low
ovf  out  2  [0] m2s overrun, [1] s2m overrun (see optional feature)

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: m2s_data=s2m_data=RSTVAL; m2s_full=s2m_full=0; main_dout=RSTVAL; mcu_irqn=1; ovf=0. Edge-detect registers reset to idle: cs=0, strobes=1.
- Reset mid-transfer drops everything to these values. A pending strobe does not re-fire after reset.
- Main access start: first clk where main_cs=1 and the previous sample of main_cs was 0. Only one action per access, whatever main_cs length.
- Main write start: m2s_data<=main_din; m2s_full<=1.
- Main read start: main_dout<=s2m_data; s2m_full<=0. main_dout is held until the next read start.
- MCU read: mcu_din = m2s_data, registered, updated every clk. On the mcu_rd_n rising edge (end of read): m2s_full<=0.
- MCU write: on the mcu_wr_n rising edge: s2m_data<=mcu_dout (sampled the same clk); s2m_full<=1.
- mcu_irqn = ~m2s_full, registered. It deasserts 1 clk after the MCU read ends.
- Latency: every flag, mcu_st and mcu_irqn change is visible the clk after the triggering edge.
- Simultaneous set and clear on one flag in the same clk: set wins. Cases: main write start plus MCU read end; MCU write end plus main read start. The newly written byte must not be lost.
- Simultaneous main write and MCU write: independent, both take effect.
- Strobes are synchronous to clk. No synchroniser; one register stage for edge detection only.
- Writing when already full overwrites data; flag stays 1.

Optional Feature:
Macro JTKUNIO_MBOX_OVF_EN.
- Defined:
  - ovf[0] sets when a main write start occurs while m2s_full=1.
  - ovf[1] sets when an MCU write end occurs while s2m_full=1.
  - Both are sticky; only rst clears them.
  - Overwrite behaviour is unchanged.
- Not defined: ovf tied to 0, no extra registers.

Test Plan:
- Main write 8'hA5 with main_cs held 16 clk -> mcu_st=2'b01 and mcu_irqn=0 one clk after cs rise, mcu_din=A5. Data captured only once: change main_din mid-access to 8'h00, mcu_din stays A5.
- MCU pulses mcu_rd_n low 4 clk then high -> m2s_full=0 and mcu_irqn=1 one clk after the rising edge; mcu_din still A5.
- MCU writes 8'h3C (mcu_wr_n pulse) -> mcu_st[1]=1. Main read -> main_dout=3C, mcu_st[1]=0 next clk, main_dout stays 3C after cs drops.
- MCU write end of 8'h77 in the same clk as main read start, with s2m_full=1 holding 8'h11 -> main_dout=11, s2m_full=1, s2m_data=77. A subsequent read returns 77.
- Two main writes (8'h01, then 8'h02) without an MCU read -> mcu_din=02, m2s_full=1. With JTKUNIO_MBOX_OVF_EN, ovf=2'b01 and it stays after the MCU read; without it, ovf=0.
- Assert rst while main_cs=1 and mcu_rd_n=0, release with both still held -> all outputs at reset values. No access fires until main_cs falls and rises again; no read-end fires until mcu_rd_n falls and rises again.

Source files
------------

// File: rtl/jtkunio_mcu_mbox.sv
// Kunio main-CPU <-> protection-MCU one-byte mailbox, one latch per direction with full flags; optional sticky overrun flags under JTKUNIO_MBOX_OVF_EN.
// All flag/status/irq changes appear 1 clk after the triggering strobe edge; no backpressure, writing a full latch overwrites it.
module jtkunio_mcu_mbox #(
    parameter logic [7:0] RSTVAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_cs,
    input  logic       main_rnw,
    input  logic [7:0] main_din,
    output logic [7:0] main_dout,
    output logic [1:0] mcu_st,
    input  logic       mcu_rd_n,
    input  logic       mcu_wr_n,
    input  logic [7:0] mcu_dout,
    output logic [7:0] mcu_din,
    output logic       mcu_irqn,
    output logic [1:0] ovf
);

    logic [7:0] m2s_data_q, m2s_data_d;
    logic [7:0] s2m_data_q, s2m_data_d;
    logic       m2s_full_q, m2s_full_d;
    logic       s2m_full_q, s2m_full_d;
    logic [7:0] main_dout_q, main_dout_d;
    logic [7:0] mcu_din_q, mcu_din_d;
    logic       mcu_irqn_q, mcu_irqn_d;
    logic       cs_q, cs_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       cs_arm_q, cs_arm_d;
    logic       rd_arm_q, rd_arm_d;
    logic       wr_arm_q, wr_arm_d;

    logic       main_wr_start, main_rd_start;
    logic       mcu_rd_end, mcu_wr_end;

    // Each edge detector only arms once its input has been seen idle after
    // reset, so a strobe already active across reset cannot fire on release.
    always_comb begin
        main_wr_start = main_cs & ~cs_q & cs_arm_q & ~main_rnw;
        main_rd_start = main_cs & ~cs_q & cs_arm_q &  main_rnw;
        mcu_rd_end    = mcu_rd_n & ~rd_n_q & rd_arm_q;
        mcu_wr_end    = mcu_wr_n & ~wr_n_q & wr_arm_q;

        cs_d     = main_cs;
        rd_n_d   = mcu_rd_n;
        wr_n_d   = mcu_wr_n;
        cs_arm_d = cs_arm_q | ~main_cs;
        rd_arm_d = rd_arm_q | mcu_rd_n;
        wr_arm_d = wr_arm_q | mcu_wr_n;

        m2s_data_d  = m2s_data_q;
        s2m_data_d  = s2m_data_q;
        m2s_full_d  = m2s_full_q;
        s2m_full_d  = s2m_full_q;
        main_dout_d = main_dout_q;

        // Clear first, set second: a set in the same clk must win.
        if (mcu_rd_end)    m2s_full_d = 1'b0;
        if (main_wr_start) begin
            m2s_data_d = main_din;
            m2s_full_d = 1'b1;
        end
        if (main_rd_start) begin
            main_dout_d = s2m_data_q;
            s2m_full_d  = 1'b0;
        end
        if (mcu_wr_end) begin
            s2m_data_d = mcu_dout;
            s2m_full_d = 1'b1;
        end

        mcu_din_d  = m2s_data_d;
        mcu_irqn_d = ~m2s_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2s_data_q  <= RSTVAL;
            s2m_data_q  <= RSTVAL;
            m2s_full_q  <= 1'b0;
            s2m_full_q  <= 1'b0;
            main_dout_q <= RSTVAL;
            mcu_din_q   <= RSTVAL;
            mcu_irqn_q  <= 1'b1;
            cs_q        <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cs_arm_q    <= 1'b0;
            rd_arm_q    <= 1'b0;
            wr_arm_q    <= 1'b0;
        end else begin
            m2s_data_q  <= m2s_data_d;
            s2m_data_q  <= s2m_data_d;
            m2s_full_q  <= m2s_full_d;
            s2m_full_q  <= s2m_full_d;
            main_dout_q <= main_dout_d;
            mcu_din_q   <= mcu_din_d;
            mcu_irqn_q  <= mcu_irqn_d;
            cs_q        <= cs_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cs_arm_q    <= cs_arm_d;
            rd_arm_q    <= rd_arm_d;
            wr_arm_q    <= wr_arm_d;
        end
    end

`ifdef JTKUNIO_MBOX_OVF_EN
    logic [1:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d    = ovf_q;
        ovf_d[0] = ovf_q[0] | (main_wr_start & m2s_full_q);
        ovf_d[1] = ovf_q[1] | (mcu_wr_end & s2m_full_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 2'b00;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 2'b00;
`endif

    assign main_dout = main_dout_q;
    assign mcu_st    = {s2m_full_q, m2s_full_q};
    assign mcu_din   = mcu_din_q;
    assign mcu_irqn  = mcu_irqn_q;

endmodule

// File: tb/tb_jtkunio_mcu_mbox.sv
// Directed bench for jtkunio_mcu_mbox: expectations queued as stimulus is driven, popped and compared after each clk.
module tb_jtkunio_mcu_mbox;

    logic       clk;
    logic       rst;
    logic       main_cs;
    logic       main_rnw;
    logic [7:0] main_din;
    logic [7:0] main_dout;
    logic [1:0] mcu_st;
    logic       mcu_rd_n;
    logic       mcu_wr_n;
    logic [7:0] mcu_dout;
    logic [7:0] mcu_din;
    logic       mcu_irqn;
    logic [1:0] ovf;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    jtkunio_mcu_mbox #(.RSTVAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .main_cs   (main_cs),
        .main_rnw  (main_rnw),
        .main_din  (main_din),
        .main_dout (main_dout),
        .mcu_st    (mcu_st),
        .mcu_rd_n  (mcu_rd_n),
        .mcu_wr_n  (mcu_wr_n),
        .mcu_dout  (mcu_dout),
        .mcu_din   (mcu_din),
        .mcu_irqn  (mcu_irqn),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef JTKUNIO_MBOX_OVF_EN
    localparam logic [7:0] OVF_AFTER_DOUBLE = 8'h01;
`else
    localparam logic [7:0] OVF_AFTER_DOUBLE = 8'h00;
`endif

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check_next(input logic [7:0] obs);
        string      tag;
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) passed++;
            else begin
                failed++;
                $error("FAIL %s observed=%h required=%h", tag, obs, exp);
            end
        end
    endtask

    // Queue the full output picture, then compare it against the DUT.
    task automatic expect_all(input string tag, input logic [1:0] st, input logic irqn,
                              input logic [7:0] din, input logic [7:0] dout);
        expect_val({tag, "_st"},   {6'b0, st});
        expect_val({tag, "_irqn"}, {7'b0, irqn});
        expect_val({tag, "_din"},  din);
        expect_val({tag, "_dout"}, dout);
        check_next({6'b0, mcu_st});
        check_next({7'b0, mcu_irqn});
        check_next(mcu_din);
        check_next(main_dout);
    endtask

    initial begin
        rst = 1'b1; main_cs = 1'b0; main_rnw = 1'b1; main_din = 8'h00;
        mcu_rd_n = 1'b1; mcu_wr_n = 1'b1; mcu_dout = 8'h00;
        tick(2);
        expect_all("reset", 2'b00, 1'b1, 8'h00, 8'h00);
        expect_val("reset_ovf", 8'h00); check_next({6'b0, ovf});
        rst = 1'b0;
        tick(2);

        // Main write, held 16 clk, data changed mid-access.
        main_cs = 1'b1; main_rnw = 1'b0; main_din = 8'hA5;
        tick();
        expect_all("mwr_first", 2'b01, 1'b0, 8'hA5, 8'h00);
        main_din = 8'h00;
        tick(15);
        expect_all("mwr_held", 2'b01, 1'b0, 8'hA5, 8'h00);
        main_cs = 1'b0;
        tick();

        // MCU read: flag clears one clk after rd_n rises.
        mcu_rd_n = 1'b0;
        tick(4);
        expect_all("mrd_low", 2'b01, 1'b0, 8'hA5, 8'h00);
        mcu_rd_n = 1'b1;
        tick();
        expect_all("mrd_end", 2'b00, 1'b1, 8'hA5, 8'h00);

        // MCU write 3C then main read.
        mcu_dout = 8'h3C; mcu_wr_n = 1'b0;
        tick();
        mcu_wr_n = 1'b1;
        tick();
        expect_all("swr_3c", 2'b10, 1'b1, 8'hA5, 8'h00);
        main_cs = 1'b1; main_rnw = 1'b1;
        tick();
        expect_all("rd_3c", 2'b00, 1'b1, 8'hA5, 8'h3C);
        tick();
        main_cs = 1'b0;
        tick(2);
        expect_all("rd_3c_hold", 2'b00, 1'b1, 8'hA5, 8'h3C);

        // Collision: MCU write end of 77 with main read start while 11 is pending.
        mcu_dout = 8'h11; mcu_wr_n = 1'b0;
        tick();
        mcu_wr_n = 1'b1;
        tick();
        expect_val("pend_11_st", 8'h02); check_next({6'b0, mcu_st});
        mcu_wr_n = 1'b0;
        tick();
        mcu_wr_n = 1'b1; mcu_dout = 8'h77; main_cs = 1'b1; main_rnw = 1'b1;
        tick();
        expect_all("collide", 2'b10, 1'b1, 8'hA5, 8'h11);
        main_cs = 1'b0;
        tick();
        main_cs = 1'b1;
        tick();
        expect_all("rd_77", 2'b00, 1'b1, 8'hA5, 8'h77);
        main_cs = 1'b0;
        tick();

        // Two main writes without an MCU read.
        main_cs = 1'b1; main_rnw = 1'b0; main_din = 8'h01;
        tick();
        main_cs = 1'b0;
        tick();
        main_cs = 1'b1; main_din = 8'h02;
        tick();
        expect_all("dbl_wr", 2'b01, 1'b0, 8'h02, 8'h77);
        main_cs = 1'b0;
        tick();
        expect_val("dbl_ovf", OVF_AFTER_DOUBLE); check_next({6'b0, ovf});
        mcu_rd_n = 1'b0;
        tick(2);
        mcu_rd_n = 1'b1;
        tick();
        expect_all("dbl_rd", 2'b00, 1'b1, 8'h02, 8'h77);
        expect_val("dbl_ovf_sticky", OVF_AFTER_DOUBLE); check_next({6'b0, ovf});

        // Reset with main_cs and mcu_rd_n both active, released while still held.
        main_cs = 1'b1; main_rnw = 1'b0; main_din = 8'h99; mcu_rd_n = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        expect_all("rst_async", 2'b00, 1'b1, 8'h00, 8'h00);
        expect_val("rst_async_ovf", 8'h00); check_next({6'b0, ovf});
        tick(2);
        rst = 1'b0;
        tick(3);
        expect_all("rst_held", 2'b00, 1'b1, 8'h00, 8'h00);
        main_cs = 1'b0;
        tick();
        main_cs = 1'b1; main_din = 8'hC3;
        tick();
        expect_all("rst_rewr", 2'b01, 1'b0, 8'hC3, 8'h00);
        main_cs = 1'b0;
        mcu_rd_n = 1'b1;
        tick();
        expect_all("rst_no_rdend", 2'b01, 1'b0, 8'hC3, 8'h00);
        mcu_rd_n = 1'b0;
        tick();
        mcu_rd_n = 1'b1;
        tick();
        expect_all("rst_rdend", 2'b00, 1'b1, 8'hC3, 8'h00);
        expect_val("rst_ovf", 8'h00); check_next({6'b0, ovf});

        if (exp_q.size() != 0) begin
            checks++;
            failed++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
